instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Fetch stage of the 5-stage RISC-V pipeline: owns the PC register and the IF/ID pipeline register, issues requests to a variable-latency instruction memory, and is the consumer of the PCWrite/IF_ID_Write stall controls produced by hazard detection. It also accepts branch redirects resolved in ID. It delivers one instruction per cycle into IF/ID when memory answers in the request cycle and no stall is present, and inserts NOP bubbles otherwise.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP, 32'h0000_0013, instruction written into IF/ID for a bubble (addi x0,x0,0)

- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  begin fetching; sampled only in IDLE
- PCWrite_i  input  1  PC update enable from hazard detection
- IF_ID_Write_i  input  1  IF/ID update enable from hazard detection
- Branch_i  input  1  taken branch/jump resolved in ID
- BranchTarget_i  input  XLEN  redirect address, valid with Branch_i
- imem_req_o  output  1  instruction memory request
- imem_addr_o  output  XLEN  request address (= PC)
- imem_ack_i  input  1  memory response valid; may assert in the request cycle
- imem_data_i  input  32  instruction, valid with imem_ack_i
- IF_ID_pc_o  output  XLEN  PC of instruction in IF/ID
- IF_ID_inst_o  output  32  instruction in IF/ID
- IF_ID_valid_o  output  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- advance = PCWrite_i & IF_ID_Write_i. redirect = Branch_i & IF_ID_Write_i; Branch_i is ignored when IF_ID_Write_i=0.
- States: IDLE, REQ, HOLD. Registers: pc, hold_inst, redir_pend, redir_tgt.
- IDLE: imem_req_o=0; IF/ID keeps reset bubble. start_i=1 -> REQ.
- REQ: imem_req_o=1, imem_addr_o=pc; address held stable until ack (never changes mid-request).
  - no ack, redirect: redir_pend<=1, redir_tgt<=BranchTarget_i; IF/ID<=bubble.
  - no ack, IF_ID_Write_i=1: IF/ID<=bubble (pc=pc, inst=NOP, valid=0). IF_ID_Write_i=0: IF/ID holds.
  - ack with redirect or redir_pend: data discarded; pc<=(redirect ? BranchTarget_i : redir_tgt); redir_pend<=0; IF/ID<=bubble; stay REQ. Same-cycle Branch_i wins over redir_pend.
  - ack, advance: IF/ID<={pc, imem_data_i, 1}; pc<=pc+4; stay REQ.
  - ack, not advance: hold_inst<=imem_data_i; IF/ID holds; -> HOLD.
- HOLD: imem_req_o=0. advance -> IF/ID<={pc, hold_inst, 1}, pc<=pc+4, -> REQ. redirect -> hold_inst dropped, pc<=BranchTarget_i, IF/ID<=bubble, -> REQ. Otherwise hold.
- pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0). No alignment checking; BranchTarget_i used as given.
- Once started, fetching continues until reset; start_i ignored outside IDLE.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, IF_ID_pc_o=0, IF_ID_inst_o=NOP, IF_ID_valid_o=0, redir_pend=0, hold_inst=NOP.
- start_i high in cycle N -> imem_req_o high in N+1; with same-cycle ack, first valid instruction visible at IF/ID in N+2.
- Zero-wait memory: one instruction per cycle. k wait cycles: k bubbles per instruction.
- Redirect: first target instruction appears in IF/ID two cycles after redirect cycle (zero-wait), i.e. exactly one bubble.
- IF/ID outputs and imem_req_o/imem_addr_o are registered/state-decoded; no combinational path from imem_ack_i to outputs.
- Reset mid-request: request abandoned at the reset edge; imem_req_o=0 next cycle; memory must tolerate abandonment.

## Test plan
- Reset, start_i pulse, always-ack memory returning addr-based data -> IF/ID shows pc 0,4,8,... with valid=1 each cycle from cycle 2 after start.
- 2-wait-state memory -> each instruction preceded by two bubbles (valid=0, inst=32'h13); imem_addr_o stable across wait cycles.
- Ack with PCWrite_i=IF_ID_Write_i=0 for 3 cycles -> HOLD, imem_req_o=0, IF/ID unchanged; on release held instruction enters IF/ID, pc+4, no fetch lost or duplicated.
- Branch_i=1, target 0x100 while ack pending -> returned data dropped, next request addr 0x100, single bubble; Branch_i with IF_ID_Write_i=0 -> ignored.
- RESET_PC=32'hFFFF_FFF8, zero-wait -> pc sequence FFF8, FFFC, 0000, 0004.
- rst_i asserted in REQ with outstanding request -> next cycle all outputs at reset values, state IDLE, start_i required to resume.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC, IF/ID register, variable-latency imem fetch
module instruction_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            PCWrite_i,
  input  logic            IF_ID_Write_i,
  input  logic            Branch_i,
  input  logic [XLEN-1:0] BranchTarget_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic [XLEN-1:0] IF_ID_pc_o,
  output logic [31:0]     IF_ID_inst_o,
  output logic            IF_ID_valid_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic [31:0]     hold_inst, hold_inst_nx;
  logic            redir_pend, redir_pend_nx;
  logic [XLEN-1:0] redir_tgt, redir_tgt_nx;
  logic [XLEN-1:0] ifid_pc, ifid_pc_nx;
  logic [31:0]     ifid_inst, ifid_inst_nx;
  logic            ifid_valid, ifid_valid_nx;

  logic            advance;
  logic            redirect;
  logic [XLEN-1:0] pc_plus4;

  assign advance  = PCWrite_i & IF_ID_Write_i;
  // A branch seen while ID is frozen refers to a stalled instruction and is not acted on yet.
  assign redirect = Branch_i & IF_ID_Write_i;
  assign pc_plus4 = pc + XLEN'(4);

  // Request and address come straight from registers, never from imem_ack_i.
  assign imem_req_o    = (state == REQ);
  assign imem_addr_o   = pc;
  assign IF_ID_pc_o    = ifid_pc;
  assign IF_ID_inst_o  = ifid_inst;
  assign IF_ID_valid_o = ifid_valid;

  // State and datapath register update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      hold_inst  <= NOP;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
      ifid_pc    <= '0;
      ifid_inst  <= NOP;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      hold_inst  <= hold_inst_nx;
      redir_pend <= redir_pend_nx;
      redir_tgt  <= redir_tgt_nx;
      ifid_pc    <= ifid_pc_nx;
      ifid_inst  <= ifid_inst_nx;
      ifid_valid <= ifid_valid_nx;
    end
  end

  // Next-state logic: fetch sequencing, redirect handling and bubble insertion.
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    hold_inst_nx  = hold_inst;
    redir_pend_nx = redir_pend;
    redir_tgt_nx  = redir_tgt;
    ifid_pc_nx    = ifid_pc;
    ifid_inst_nx  = ifid_inst;
    ifid_valid_nx = ifid_valid;

    case (state)
      IDLE: begin
        if (start_i) state_nx = REQ;
      end

      REQ: begin
        if (!imem_ack_i) begin
          // Address must stay put until the memory answers, so a redirect is parked.
          if (redirect) begin
            redir_pend_nx = 1'b1;
            redir_tgt_nx  = BranchTarget_i;
          end
          if (IF_ID_Write_i) begin
            ifid_pc_nx    = pc;
            ifid_inst_nx  = NOP;
            ifid_valid_nx = 1'b0;
          end
        end else if (redirect || redir_pend) begin
          // Returned word is wrong-path; a fresh branch overrides a parked one.
          pc_nx         = redirect ? BranchTarget_i : redir_tgt;
          redir_pend_nx = 1'b0;
          ifid_pc_nx    = pc;
          ifid_inst_nx  = NOP;
          ifid_valid_nx = 1'b0;
        end else if (advance) begin
          ifid_pc_nx    = pc;
          ifid_inst_nx  = imem_data_i;
          ifid_valid_nx = 1'b1;
          pc_nx         = pc_plus4;
        end else begin
          // Memory answered but the pipe is stalled; keep the word until release.
          hold_inst_nx = imem_data_i;
          state_nx     = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          hold_inst_nx  = NOP;
          pc_nx         = BranchTarget_i;
          ifid_pc_nx    = pc;
          ifid_inst_nx  = NOP;
          ifid_valid_nx = 1'b0;
          state_nx      = REQ;
        end else if (advance) begin
          ifid_pc_nx    = pc;
          ifid_inst_nx  = hold_inst;
          ifid_valid_nx = 1'b1;
          pc_nx         = pc_plus4;
          state_nx      = REQ;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
